// File: rtl/proj_lif_sched.sv
// ============================================================================
// Module   : proj_lif_sched
// Purpose  : Leaky integrate-and-fire scheduler: streams one delta per neuron
//            per timestep through a 3-stage membrane update pipeline.
//            Optional spike counter: define PROJ_LIF_SPIKE_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module proj_lif_sched #(
   parameter int ADD9_ALL_BITS = 16,
   parameter int NEURON_MAX    = 64,
   parameter int TIME_STEPS    = 4,
   localparam int ADDR_W       = (NEURON_MAX > 1) ? $clog2(NEURON_MAX) : 1,
   localparam int TS_W         = (TIME_STEPS > 1) ? $clog2(TIME_STEPS) : 1,
   localparam int CNT_W        = ADDR_W + TS_W + 1
) (
   input  logic                     s_clk,
   input  logic                     s_rst_n,
   input  logic                     i_start,
   input  logic [ADDR_W:0]          i_neuron_num,
   input  logic [ADD9_ALL_BITS-1:0] i_threshold,
   input  logic [ADD9_ALL_BITS-1:0] i_delta,
   input  logic                     i_delta_valid,
   output logic                     o_delta_ready,
   output logic                     o_spike,
   output logic                     o_spike_valid,
   output logic [ADDR_W-1:0]        o_spike_idx,
   output logic [TS_W-1:0]          o_spike_t,
   output logic                     o_busy,
   output logic                     o_done
`ifdef PROJ_LIF_SPIKE_CNT_EN
   ,
   output logic [CNT_W-1:0]         o_spike_cnt
`endif
);

   localparam int W = ADD9_ALL_BITS;
   localparam logic [ADDR_W:0] NMAX_C  = (ADDR_W+1)'(NEURON_MAX);
   localparam logic [TS_W-1:0] TS_LAST = TS_W'(TIME_STEPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d, n_last_q, n_last_d;
   logic [TS_W-1:0]   t_q, t_d;
   logic [W-1:0]      thr_q, thr_d;

   logic              s1_valid_q, s1_valid_d;
   logic [W-1:0]      s1_delta_q, s1_delta_d, s1_pre_q, s1_pre_d;
   logic [ADDR_W-1:0] s1_idx_q, s1_idx_d;
   logic [TS_W-1:0]   s1_t_q, s1_t_d;

   logic              s2_valid_q, s2_valid_d, s2_spike_q, s2_spike_d;
   logic [W-1:0]      s2_mem_q, s2_mem_d;
   logic [ADDR_W-1:0] s2_idx_q, s2_idx_d;
   logic [TS_W-1:0]   s2_t_q, s2_t_d;

   logic [W-1:0]      mem_buf [NEURON_MAX];

   logic              accept;
   logic [ADDR_W:0]   n_eff;
   logic [W-1:0]      sum_raw, sum_sh, s1_next, pre_mem;
   logic              s1_spike;

   assign accept = (state_q == ST_RUN) && i_delta_valid;

   always_comb begin
      n_eff = i_neuron_num;
      if (i_neuron_num == '0)
         n_eff = (ADDR_W+1)'(1);
      else if (i_neuron_num > NMAX_C)
         n_eff = NMAX_C;
   end

   // S1: membrane update, wraps at W bits before the arithmetic halving
   always_comb begin
      sum_raw  = s1_delta_q + s1_pre_q;
      sum_sh   = $signed(sum_raw) >>> 1;
      s1_spike = !sum_sh[W-1] && ($signed(sum_sh) >= $signed(thr_q));
      s1_next  = s1_spike ? '0 : sum_sh;
   end

   // Youngest in-flight write wins, so N=1/N=2 see the unpipelined result
   always_comb begin
      pre_mem = mem_buf[idx_q];
      if (t_q == '0)
         pre_mem = '0;
      else if (s1_valid_q && (s1_idx_q == idx_q))
         pre_mem = s1_next;
      else if (s2_valid_q && (s2_idx_q == idx_q))
         pre_mem = s2_mem_q;
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      t_d      = t_q;
      n_last_d = n_last_q;
      thr_d    = thr_q;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d  = ST_RUN;
               idx_d    = '0;
               t_d      = '0;
               n_last_d = ADDR_W'(n_eff - (ADDR_W+1)'(1));
               thr_d    = i_threshold;
            end
         end
         ST_RUN: begin
            if (accept) begin
               if (idx_q == n_last_q) begin
                  idx_d = '0;
                  if (t_q == TS_LAST)
                     state_d = ST_DRAIN;
                  else
                     t_d = t_q + TS_W'(1);
               end else begin
                  idx_d = idx_q + ADDR_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (!s1_valid_q && !s2_valid_q)
               state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s1_valid_d = accept;
      s1_delta_d = accept ? i_delta : s1_delta_q;
      s1_pre_d   = accept ? pre_mem : s1_pre_q;
      s1_idx_d   = accept ? idx_q   : s1_idx_q;
      s1_t_d     = accept ? t_q     : s1_t_q;
      s2_valid_d = s1_valid_q;
      s2_spike_d = s1_valid_q && s1_spike;
      s2_mem_d   = s1_valid_q ? s1_next  : s2_mem_q;
      s2_idx_d   = s1_valid_q ? s1_idx_q : s2_idx_q;
      s2_t_d     = s1_valid_q ? s1_t_q   : s2_t_q;
   end

   always_ff @(posedge s_clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         t_q        <= '0;
         n_last_q   <= '0;
         thr_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_delta_q <= '0;
         s1_pre_q   <= '0;
         s1_idx_q   <= '0;
         s1_t_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_spike_q <= 1'b0;
         s2_mem_q   <= '0;
         s2_idx_q   <= '0;
         s2_t_q     <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         t_q        <= t_d;
         n_last_q   <= n_last_d;
         thr_q      <= thr_d;
         s1_valid_q <= s1_valid_d;
         s1_delta_q <= s1_delta_d;
         s1_pre_q   <= s1_pre_d;
         s1_idx_q   <= s1_idx_d;
         s1_t_q     <= s1_t_d;
         s2_valid_q <= s2_valid_d;
         s2_spike_q <= s2_spike_d;
         s2_mem_q   <= s2_mem_d;
         s2_idx_q   <= s2_idx_d;
         s2_t_q     <= s2_t_d;
      end
   end

   // Membrane storage is never reset; t=0 reads are forced to zero instead
   always_ff @(posedge s_clk) begin
      if (s2_valid_q)
         mem_buf[s2_idx_q] <= s2_mem_q;
   end

   assign o_delta_ready = (state_q == ST_RUN);
   assign o_busy        = (state_q != ST_IDLE);
   assign o_done        = (state_q == ST_DONE);
   assign o_spike_valid = s2_valid_q;
   assign o_spike       = s2_spike_q;
   assign o_spike_idx   = s2_idx_q;
   assign o_spike_t     = s2_t_q;

`ifdef PROJ_LIF_SPIKE_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == ST_IDLE) && i_start)
         cnt_d = '0;
      else if (s1_valid_q && s1_spike)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge s_clk or negedge s_rst_n) begin
      if (!s_rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign o_spike_cnt = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_proj_lif_sched.sv
// ============================================================================
// Module   : tb_proj_lif_sched
// Purpose  : Directed table-driven bench for proj_lif_sched (frame vectors,
//            bubbles, forwarding, clamping, mid-run reset).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_proj_lif_sched;
   localparam int W  = 16;
   localparam int NM = 64;
   localparam int TS = 4;
   localparam int AW = 6;
   localparam int TW = 2;

   logic          s_clk = 1'b0;
   logic          s_rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic [AW:0]   i_neuron_num = '0;
   logic [W-1:0]  i_threshold = '0;
   logic [W-1:0]  i_delta = '0;
   logic          i_delta_valid = 1'b0;
   logic          o_delta_ready, o_spike, o_spike_valid, o_busy, o_done;
   logic [AW-1:0] o_spike_idx;
   logic [TW-1:0] o_spike_t;
`ifdef PROJ_LIF_SPIKE_CNT_EN
   logic [AW+TW:0] o_spike_cnt;
`endif

   proj_lif_sched dut (
      .s_clk(s_clk), .s_rst_n(s_rst_n), .i_start(i_start),
      .i_neuron_num(i_neuron_num), .i_threshold(i_threshold),
      .i_delta(i_delta), .i_delta_valid(i_delta_valid),
      .o_delta_ready(o_delta_ready), .o_spike(o_spike),
      .o_spike_valid(o_spike_valid), .o_spike_idx(o_spike_idx),
      .o_spike_t(o_spike_t), .o_busy(o_busy), .o_done(o_done)
`ifdef PROJ_LIF_SPIKE_CNT_EN
      , .o_spike_cnt(o_spike_cnt)
`endif
   );

   always #5 s_clk = ~s_clk;

   // One frame: same delta to every neuron/timestep; exp[t] = spike at step t
   typedef struct {
      int         n;
      int         thr;
      int         delta;
      logic [3:0] exp;
      bit         bub;
      bit         poke;
   } vec_t;

   typedef struct {
      int idx;
      int t;
      bit spk;
      int due;
   } exp_t;

   vec_t vecs[15];
   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_busy"}, {31'd0, o_busy}, 0);
      chk({tag, "_ready"}, {31'd0, o_delta_ready}, 0);
      chk({tag, "_spike_valid"}, {31'd0, o_spike_valid}, 0);
      chk({tag, "_spike"}, {31'd0, o_spike}, 0);
      chk({tag, "_spike_idx"}, {26'd0, o_spike_idx}, 0);
      chk({tag, "_spike_t"}, {30'd0, o_spike_t}, 0);
      chk({tag, "_done"}, {31'd0, o_done}, 0);
`ifdef PROJ_LIF_SPIKE_CNT_EN
      chk({tag, "_spike_cnt"}, {23'd0, o_spike_cnt}, 0);
`endif
   endtask

   task automatic run_frame(input int n_in, input int thr, input int delta,
                            input logic [3:0] exp, input bit bub, input bit poke,
                            input int abort_at);
      int n, total, acc;
      bit finished, v;
      n     = (n_in < 1) ? 1 : ((n_in > NM) ? NM : n_in);
      total = n * TS;
      acc   = 0;
      finished = 1'b0;
      q.delete();
      @(negedge s_clk);
      i_start = 1'b1; i_neuron_num = n_in[AW:0];
      i_threshold = thr[W-1:0]; i_delta = delta[W-1:0];
      @(negedge s_clk);
      i_start = 1'b0;
      chk("busy_after_start", {31'd0, o_busy}, 1);
      for (int c = 0; c < 3000 && !finished; c++) begin
         if (q.size() > 0 && q[0].due == c) begin
            chk("spike_valid", {31'd0, o_spike_valid}, 1);
            chk("spike_bit", {31'd0, o_spike}, {31'd0, q[0].spk});
            chk("spike_idx", {26'd0, o_spike_idx}, q[0].idx);
            chk("spike_t", {30'd0, o_spike_t}, q[0].t);
            void'(q.pop_front());
         end else begin
            chk("spike_valid_idle", {31'd0, o_spike_valid}, 0);
            chk("spike_bit_idle", {31'd0, o_spike}, 0);
         end
         if (o_done) begin
            chk("done_pipe_empty", q.size(), 0);
            chk("done_all_accepted", acc, total);
            finished = 1'b1;
         end else if (acc == total) begin
            chk("drain_ready_low", {31'd0, o_delta_ready}, 0);
            chk("drain_busy", {31'd0, o_busy}, 1);
         end
         if (abort_at > 0 && acc == abort_at) begin
            i_delta_valid = 1'b0;
            #2 s_rst_n = 1'b0;
            #1 reset_checks("midrun_reset");
            @(negedge s_clk);
            s_rst_n = 1'b1;
            q.delete();
            return;
         end
         if (!finished) begin
            i_start = 1'b0;
            if (poke && acc == 2) begin
               i_start = 1'b1; i_neuron_num = 3; i_threshold = 100;
            end
            if (acc < total) begin
               v = bub ? 1'($urandom_range(0, 1)) : 1'b1;
               i_delta_valid = v;
               if (v && o_delta_ready) begin
                  q.push_back('{acc % n, acc / n, exp[acc / n], c + 2});
                  acc++;
               end
            end else begin
               i_delta_valid = 1'b0;
            end
            @(negedge s_clk);
         end
      end
      if (!finished)
         chk("frame_timeout", 0, 1);
      i_start = 1'b0;
      i_delta_valid = 1'b0;
      @(negedge s_clk);
      chk("done_one_cycle", {31'd0, o_done}, 0);
      chk("idle_busy", {31'd0, o_busy}, 0);
      chk("idle_ready", {31'd0, o_delta_ready}, 0);
`ifdef PROJ_LIF_SPIKE_CNT_EN
      chk("spike_cnt", {23'd0, o_spike_cnt}, $countones(exp) * n);
`endif
   endtask

   initial begin
      // n, thr, delta, per-step spike pattern (bit t), bubbles, start poke
      vecs[0]  = '{4,      10,    12, 4'b0100, 1'b0, 1'b0}; // 6,9,10*,6
      vecs[1]  = '{1,       8,    20, 4'b1111, 1'b0, 1'b0}; // 10* every step
      vecs[2]  = '{1,       8,    10, 4'b0100, 1'b0, 1'b0}; // 5,7,8*,5 (S1 fwd)
      vecs[3]  = '{2,       7,    10, 4'b1010, 1'b0, 1'b0}; // 5,7*,5,7* (S2 fwd)
      vecs[4]  = '{2,       1,    -6, 4'b0000, 1'b0, 1'b0}; // -3,-5,-6,-6
      vecs[5]  = '{2,      -4,    -6, 4'b0000, 1'b0, 1'b0}; // -3 >= -4 but negative
      vecs[6]  = '{3,       0,     0, 4'b1111, 1'b0, 1'b0}; // 0 >= 0 fires
      vecs[7]  = '{1,   15001, 30000, 4'b0000, 1'b0, 1'b0}; // 15000,-10268,9866,-12835
      vecs[8]  = '{5,       5,     9, 4'b1010, 1'b0, 1'b0}; // 4,6*,4,6*
      vecs[9]  = '{0,       8,    20, 4'b1111, 1'b0, 1'b0}; // N=0 -> 1
      vecs[10] = '{70,      0,     0, 4'b1111, 1'b0, 1'b0}; // N>64 -> 64
      vecs[11] = '{8,      10,    12, 4'b0100, 1'b0, 1'b0};
      vecs[12] = '{8,      10,    12, 4'b0100, 1'b1, 1'b0}; // bubbles
      vecs[13] = '{1,       8,    10, 4'b0100, 1'b1, 1'b0}; // bubbles + fwd
      vecs[14] = '{4,      10,    12, 4'b0100, 1'b0, 1'b1}; // start ignored in RUN

      s_rst_n = 1'b0;
      repeat (2) @(negedge s_clk);
      reset_checks("reset");
      s_rst_n = 1'b1;
      @(negedge s_clk);

      for (int i = 0; i < 15; i++)
         run_frame(vecs[i].n, vecs[i].thr, vecs[i].delta, vecs[i].exp,
                   vecs[i].bub, vecs[i].poke, 0);

      // Abort mid-RUN with stale membranes of 6/9, then a fresh frame
      run_frame(4, 10, 12, 4'b0100, 1'b0, 1'b0, 6);
      run_frame(4, 10, 12, 4'b0100, 1'b0, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

`default_nettype wire
